// File: rtl/bus_arbiter2.sv
// Two-master, one-slave round-robin arbiter for the req/ack memory bus.
// One transaction in flight; an optional watchdog ends grants the slave never acknowledges.
module bus_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_out,
  input  logic        m0_wr,
  input  logic [3:0]  m0_wr_mask,
  output logic [31:0] m0_in,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_out,
  input  logic        m1_wr,
  input  logic [3:0]  m1_wr_mask,
  output logic [31:0] m1_in,
  output logic        m1_ack,
  output logic        s_req,
  output logic [31:0] s_addr,
  output logic [31:0] s_out,
  output logic        s_wr,
  output logic [3:0]  s_wr_mask,
  input  logic [31:0] s_in,
  input  logic        s_ack,
  output logic [1:0]  grant,
  output logic        timeout_err,
  output logic [1:0]  state_dbg
);

  // Handshake: a master holds req (and its address/data) until it sees a one-cycle
  // ack; the slave sees the same req/ack pair and pulses s_ack once per request.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [1:0]      state, nxt_state;
  logic            last_owner, nxt_last_owner;
  logic [WD_W-1:0] wd_cnt;
  logic            in_g0, in_g1, granted;
  logic            sel_req, wd_fire, ack_any;
  logic [31:0]     rdata;

  assign in_g0   = (state == ST_GRANT0);
  assign in_g1   = (state == ST_GRANT1);
  assign granted = in_g0 | in_g1;
  assign sel_req = (in_g0 & m0_req) | (in_g1 & m1_req);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      // A dropped request is an abort, so the watchdog only fires on a live request.
      assign wd_fire = sel_req & ~s_ack & (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wd_cnt <= '0;
        end else if (!granted || nxt_state == ST_IDLE) begin
          wd_cnt <= '0;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
    end else begin : g_no_wd
      assign wd_fire = 1'b0;
      assign wd_cnt  = '0;
    end
  endgenerate

  // The slave's ack outranks a same-cycle timeout, so real data wins the collision.
  assign ack_any = granted & (s_ack | wd_fire);
  assign rdata   = s_ack ? s_in : ERR_DATA;

  assign s_req     = sel_req & ~wd_fire;
  assign s_addr    = s_req ? (in_g1 ? m1_addr    : m0_addr)    : 32'd0;
  assign s_out     = s_req ? (in_g1 ? m1_out     : m0_out)     : 32'd0;
  assign s_wr      = s_req ? (in_g1 ? m1_wr      : m0_wr)      : 1'b0;
  assign s_wr_mask = s_req ? (in_g1 ? m1_wr_mask : m0_wr_mask) : 4'd0;

  assign m0_ack      = in_g0 & ack_any;
  assign m1_ack      = in_g1 & ack_any;
  assign m0_in       = m0_ack ? rdata : 32'd0;
  assign m1_in       = m1_ack ? rdata : 32'd0;
  assign timeout_err = wd_fire;
  assign grant       = {in_g1, in_g0};
  assign state_dbg   = state;

  always_comb begin
    nxt_state      = state;
    nxt_last_owner = last_owner;
    case (state)
      ST_IDLE: begin
        // On a tie, last_owner=1 hands the grant to m0 and vice versa.
        if (m0_req && (!m1_req || last_owner)) begin
          nxt_state = ST_GRANT0;
        end else if (m1_req) begin
          nxt_state = ST_GRANT1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (s_ack || wd_fire) begin
          nxt_state      = ST_IDLE;
          nxt_last_owner = in_g1;
        end else if (!sel_req) begin
          nxt_state = ST_IDLE;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= nxt_state;
      last_owner <= nxt_last_owner;
    end
  end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2 with a 4-cycle watchdog: reset, tie rotation,
// read routing, abort, timeout, ack/timeout collision and mid-transaction reset.
module tb_bus_arbiter2;

  logic        clk, rst;
  logic        m0_req, m0_wr, m1_req, m1_wr, s_req, s_wr, s_ack;
  logic        m0_ack, m1_ack, timeout_err;
  logic [31:0] m0_addr, m0_out, m0_in, m1_addr, m1_out, m1_in;
  logic [31:0] s_addr, s_out, s_in;
  logic [3:0]  m0_wr_mask, m1_wr_mask, s_wr_mask;
  logic [1:0]  grant, state_dbg;

  int total = 0;
  int bad   = 0;

  bus_arbiter2 #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_out(m0_out), .m0_wr(m0_wr),
    .m0_wr_mask(m0_wr_mask), .m0_in(m0_in), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_out(m1_out), .m1_wr(m1_wr),
    .m1_wr_mask(m1_wr_mask), .m1_in(m1_in), .m1_ack(m1_ack),
    .s_req(s_req), .s_addr(s_addr), .s_out(s_out), .s_wr(s_wr),
    .s_wr_mask(s_wr_mask), .s_in(s_in), .s_ack(s_ack),
    .grant(grant), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; checks follow 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic slave(input logic ack, input logic [31:0] data);
    s_ack = ack;
    s_in  = data;
  endtask

  initial begin
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h100; m0_out = 32'h55; m0_wr = 1'b1; m0_wr_mask = 4'hF;
    m1_req = 1'b0; m1_addr = 32'h0;   m1_out = 32'h0;  m1_wr = 1'b0; m1_wr_mask = 4'h0;
    slave(1'b0, 32'h0);

    // Reset with m0 requesting: nothing driven
    settle();
    check("rst_s_req", s_req, 0);
    check("rst_grant", grant, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_m0_ack", m0_ack, 0);
    @(posedge clk);
    next_cycle();
    check("rst_hold_grant", grant, 0);
    rst = 1'b1;

    // One edge after release: m0 granted
    next_cycle(); settle();
    check("rel_grant", grant, 2'b01);
    check("rel_s_req", s_req, 1);
    check("rel_s_addr", s_addr, 32'h100);
    check("rel_s_out", s_out, 32'h55);
    check("rel_s_wr", s_wr, 1);
    check("rel_mask", s_wr_mask, 4'hF);

    // m0 aborts: no ack, last_owner stays at m1
    m0_req = 1'b0; settle();
    check("ab0_s_req", s_req, 0);
    check("ab0_m0_ack", m0_ack, 0);
    next_cycle();

    // Tie: both request continuously, expect 01,00,10,00,01
    m0_req = 1'b1; m0_addr = 32'h300; m0_out = 32'hAAAA0000; m0_wr = 1'b0; m0_wr_mask = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h200; m1_out = 32'h12345678; m1_wr = 1'b1; m1_wr_mask = 4'b0011;
    settle();
    check("tie_idle_grant", grant, 2'b00);
    check("tie_idle_s_req", s_req, 0);
    next_cycle(); settle();
    check("tie_g0a_grant", grant, 2'b01);
    check("tie_g0a_s_out", s_out, 32'hAAAA0000);
    check("tie_g0a_mask", s_wr_mask, 4'h0);
    check("tie_g0a_m0_ack", m0_ack, 0);
    next_cycle(); slave(1'b1, 32'h11); settle();
    check("tie_g0b_m0_ack", m0_ack, 1);
    check("tie_g0b_m0_in", m0_in, 32'h11);
    check("tie_g0b_m1_ack", m1_ack, 0);
    check("tie_g0b_m1_in", m1_in, 0);
    next_cycle(); slave(1'b0, 32'h0); settle();
    check("tie_idle2_grant", grant, 2'b00);
    check("tie_idle2_s_req", s_req, 0);
    check("tie_idle2_m0_ack", m0_ack, 0);
    next_cycle(); settle();
    check("tie_g1a_grant", grant, 2'b10);
    check("tie_g1a_s_addr", s_addr, 32'h200);
    check("tie_g1a_s_out", s_out, 32'h12345678);
    check("tie_g1a_mask", s_wr_mask, 4'b0011);
    check("tie_g1a_s_wr", s_wr, 1);
    next_cycle(); slave(1'b1, 32'hCAFEF00D); settle();
    check("rd_m1_ack", m1_ack, 1);
    check("rd_m1_in", m1_in, 32'hCAFEF00D);
    check("rd_m0_ack", m0_ack, 0);
    check("rd_m0_in", m0_in, 0);
    next_cycle(); slave(1'b0, 32'h0); settle();
    check("tie_idle3_grant", grant, 2'b00);
    check("tie_idle3_m1_ack", m1_ack, 0);
    next_cycle(); slave(1'b1, 32'h22); settle();
    check("tie_g0c_grant", grant, 2'b01);
    check("tie_g0c_s_out", s_out, 32'hAAAA0000);
    check("tie_g0c_mask", s_wr_mask, 4'h0);
    check("tie_g0c_m0_ack", m0_ack, 1);
    check("tie_g0c_m1_ack", m1_ack, 0);

    // m1 alone, then aborts in GRANT1
    next_cycle(); slave(1'b0, 32'h0); m0_req = 1'b0; m1_wr = 1'b0; m1_addr = 32'h204;
    next_cycle(); settle();
    check("ab1_grant", grant, 2'b10);
    check("ab1_s_wr", s_wr, 0);
    m1_req = 1'b0; settle();
    check("ab1_s_req", s_req, 0);
    check("ab1_m1_ack", m1_ack, 0);
    next_cycle(); settle();
    check("ab1_idle_grant", grant, 2'b00);
    check("ab1_idle_m1_ack", m1_ack, 0);
    check("ab1_idle_err", timeout_err, 0);

    // Abort left last_owner at m0, so a tie now goes to m1
    m0_req = 1'b1; m1_req = 1'b1;
    next_cycle(); slave(1'b1, 32'h5); settle();
    check("post_ab_grant", grant, 2'b10);
    check("post_ab_m1_in", m1_in, 32'h5);
    next_cycle(); slave(1'b0, 32'h0); m1_req = 1'b0;

    // Timeout: m0 alone, slave silent
    m0_addr = 32'h400;
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); settle();
      check($sformatf("to_c%0d_grant", i), grant, 2'b01);
      check($sformatf("to_c%0d_s_req", i), s_req, 1);
      check($sformatf("to_c%0d_err", i), timeout_err, 0);
      check($sformatf("to_c%0d_ack", i), m0_ack, 0);
    end
    next_cycle(); settle();
    check("to_c4_m0_ack", m0_ack, 1);
    check("to_c4_m0_in", m0_in, 32'hDEADBEEF);
    check("to_c4_err", timeout_err, 1);
    check("to_c4_s_req", s_req, 0);
    check("to_c4_s_addr", s_addr, 0);
    check("to_c4_m1_ack", m1_ack, 0);

    // IDLE after timeout; a late s_ack here is ignored
    next_cycle(); slave(1'b1, 32'h77); settle();
    check("late_grant", grant, 2'b00);
    check("late_m0_ack", m0_ack, 0);
    check("late_m0_in", m0_in, 0);
    check("late_err", timeout_err, 0);

    // Collision: s_ack on the 4th grant cycle wins over the watchdog
    next_cycle(); slave(1'b0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      settle();
      check($sformatf("col_c%0d_err", i), timeout_err, 0);
      check($sformatf("col_c%0d_grant", i), grant, 2'b01);
      next_cycle();
    end
    slave(1'b1, 32'h1); settle();
    check("col_m0_ack", m0_ack, 1);
    check("col_m0_in", m0_in, 32'h1);
    check("col_err", timeout_err, 0);
    check("col_s_req", s_req, 1);
    next_cycle(); slave(1'b0, 32'h0); settle();
    check("col_idle_grant", grant, 2'b00);

    // Reset asserted during GRANT0 clears outputs without a clock edge
    next_cycle(); settle();
    check("mrst_pre_s_req", s_req, 1);
    check("mrst_pre_grant", grant, 2'b01);
    #1 rst = 1'b0;
    #1;
    check("mrst_s_req", s_req, 0);
    check("mrst_grant", grant, 0);
    check("mrst_s_addr", s_addr, 0);
    check("mrst_state", state_dbg, 0);
    next_cycle();
    rst = 1'b1;
    m0_req = 1'b0;
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
